// File: rtl/alu_decode.sv
// RV32I decode/issue stage feeding the registered ALU: decodes OP, OP-IMM, LUI
// and AUIPC, registers ALU operands and inserts bubbles on RAW hazards.
module alu_decode #(
  parameter int unsigned HAZARD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        stall,
  output logic [3:0]  op,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        out_valid,
  output logic        illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd_f;

  alu_op_e     d_op;
  logic [31:0] d_in1, d_in2;
  logic        d_illegal, d_we, use1, use2;
  logic        hazard, accept;

  alu_op_e     op_q;
  logic [4:0]  trk_rd [HAZARD_DEPTH];
  logic        trk_we [HAZARD_DEPTH];

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_f     = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  always_comb begin
    d_op      = ALU_ADD;
    d_in1     = '0;
    d_in2     = '0;
    d_illegal = 1'b1;
    use1      = 1'b0;
    use2      = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          d_illegal = 1'b0;
          use1      = 1'b1;
          use2      = 1'b1;
          d_in1     = rs1_data;
          d_in2     = rs2_data;
          unique case (funct3)
            3'b000: d_op = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001: begin d_op = ALU_SLL; d_in2 = {27'b0, rs2_data[4:0]}; end
            3'b010: d_op = ALU_SLT;
            3'b011: d_op = ALU_SLTU;
            3'b100: d_op = ALU_XOR;
            3'b101: begin d_op = funct7[5] ? ALU_SRA : ALU_SRL; d_in2 = {27'b0, rs2_data[4:0]}; end
            3'b110: d_op = ALU_OR;
            default: d_op = ALU_AND;
          endcase
        end
      end
      OPC_OPIMM: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) ||
            (funct3 == 3'b001 && funct7 == 7'b0000000) ||
            (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))) begin
          d_illegal = 1'b0;
          use1      = 1'b1;
          d_in1     = rs1_data;
          d_in2     = {{20{instr[31]}}, instr[31:20]};
          unique case (funct3)
            3'b000: d_op = ALU_ADD;
            3'b001: begin d_op = ALU_SLL; d_in2 = {27'b0, instr[24:20]}; end
            3'b010: d_op = ALU_SLT;
            3'b011: d_op = ALU_SLTU;
            3'b100: d_op = ALU_XOR;
            3'b101: begin d_op = funct7[5] ? ALU_SRA : ALU_SRL; d_in2 = {27'b0, instr[24:20]}; end
            3'b110: d_op = ALU_OR;
            default: d_op = ALU_AND;
          endcase
        end
      end
      OPC_LUI: begin
        d_illegal = 1'b0;
        d_in2     = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        d_illegal = 1'b0;
        d_in1     = pc;
        d_in2     = {instr[31:12], 12'b0};
      end
      default: ;
    endcase
    d_we = !d_illegal && (rd_f != 5'd0);
  end

  // Only sources the instruction actually reads can raise a hazard.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < HAZARD_DEPTH; i++) begin
      if (trk_we[i] &&
          ((use1 && rs1_addr != 5'd0 && rs1_addr == trk_rd[i]) ||
           (use2 && rs2_addr != 5'd0 && rs2_addr == trk_rd[i])))
        hazard = 1'b1;
    end
    hazard = hazard && instr_valid;
  end

  assign instr_ready = !stall && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign op          = op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= ALU_ADD;
      in1       <= '0;
      in2       <= '0;
      rd        <= '0;
      rd_we     <= 1'b0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      for (int unsigned i = 0; i < HAZARD_DEPTH; i++) begin
        trk_rd[i] <= '0;
        trk_we[i] <= 1'b0;
      end
    end else if (!stall) begin
      if (accept) begin
        op_q      <= d_op;
        in1       <= d_in1;
        in2       <= d_in2;
        rd        <= rd_f;
        rd_we     <= d_we;
        out_valid <= 1'b1;
        illegal   <= d_illegal;
        trk_rd[0] <= rd_f;
        trk_we[0] <= d_we;
      end else begin
        op_q      <= ALU_ADD;
        in1       <= '0;
        in2       <= '0;
        rd        <= '0;
        rd_we     <= 1'b0;
        out_valid <= 1'b0;
        illegal   <= 1'b0;
        trk_rd[0] <= '0;
        trk_we[0] <= 1'b0;
      end
      for (int unsigned i = 1; i < HAZARD_DEPTH; i++) begin
        trk_rd[i] <= trk_rd[i-1];
        trk_we[i] <= trk_we[i-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_decode.sv
// Self-checking bench for alu_decode: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural decode/hazard model.
module tb_alu_decode;

  localparam int D = 2;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9;

  logic clk = 1'b0;
  logic rst = 1'b0, instr_valid = 1'b0, stall = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic instr_ready, rd_we, out_valid, illegal;
  logic [4:0] rs1_addr, rs2_addr, rd;
  logic [3:0] op;
  logic [31:0] in1, in2;

  alu_decode #(.HAZARD_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .op(op),
    .in1(in1), .in2(in2), .rd(rd), .rd_we(rd_we), .out_valid(out_valid),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [31:0] regs [32];

  typedef struct packed {
    logic [3:0] op; logic [31:0] in1; logic [31:0] in2;
    logic [4:0] rd; logic we; logic valid; logic ill;
  } outv_t;

  typedef struct {
    outv_t o; bit u1; bit u2;
  } dec_t;

  outv_t exp_o;
  int hist[$];   // registers written by the last D issue slots (0 = none)

  localparam outv_t IDLE = '{op: A_ADD, in1: 32'd0, in2: 32'd0, rd: 5'd0, we: 1'b0, valid: 1'b0, ill: 1'b0};

  function automatic dec_t ref_dec(logic [31:0] w, logic [31:0] p, logic [31:0] a, logic [31:0] b);
    dec_t d;
    int opc, f3, f7, rdn;
    bit ok;
    opc = int'(w & 32'h7f); f3 = int'((w >> 12) & 7); f7 = int'(w >> 25); rdn = int'((w >> 7) & 31);
    d.o = IDLE; d.o.valid = 1; d.o.ill = 1; d.u1 = 0; d.u2 = 0;
    d.o.rd = 5'(rdn);
    if (opc == 'h33) begin
      ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      if (ok) begin
        d.o.ill = 0; d.u1 = 1; d.u2 = 1; d.o.in1 = a; d.o.in2 = b;
        case (f3)
          0: d.o.op = (f7 != 0) ? A_SUB : A_ADD;
          1: begin d.o.op = A_SLL; d.o.in2 = b % 32; end
          2: d.o.op = A_SLT;
          3: d.o.op = A_SLTU;
          4: d.o.op = A_XOR;
          5: begin d.o.op = (f7 != 0) ? A_SRA : A_SRL; d.o.in2 = b % 32; end
          6: d.o.op = A_OR;
          default: d.o.op = A_AND;
        endcase
      end
    end else if (opc == 'h13) begin
      ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1;
      if (ok) begin
        d.o.ill = 0; d.u1 = 1; d.o.in1 = a;
        d.o.in2 = 32'($signed(w) >>> 20);
        case (f3)
          0: d.o.op = A_ADD;
          1: begin d.o.op = A_SLL; d.o.in2 = (w >> 20) % 32; end
          2: d.o.op = A_SLT;
          3: d.o.op = A_SLTU;
          4: d.o.op = A_XOR;
          5: begin d.o.op = (f7 != 0) ? A_SRA : A_SRL; d.o.in2 = (w >> 20) % 32; end
          6: d.o.op = A_OR;
          default: d.o.op = A_AND;
        endcase
      end
    end else if (opc == 'h37 || opc == 'h17) begin
      d.o.ill = 0;
      d.o.in2 = w & 32'hfffff000;
      d.o.in1 = (opc == 'h17) ? p : 32'd0;
    end
    d.o.we = !d.o.ill && rdn != 0;
    return d;
  endfunction

  function automatic bit m_hazard();
    dec_t d;
    int s1, s2;
    bit h = 0;
    d = ref_dec(instr, pc, rs1_data, rs2_data);
    s1 = int'((instr >> 15) & 31); s2 = int'((instr >> 20) & 31);
    foreach (hist[i])
      if (hist[i] != 0 && ((d.u1 && s1 == hist[i]) || (d.u2 && s2 == hist[i]))) h = 1;
    return instr_valid && h;
  endfunction

  function automatic bit m_ready();
    return !stall && !m_hazard();
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p, input logic s);
    @(negedge clk);
    instr_valid = v; instr = w; pc = p; stall = s;
    rs1_data = regs[w[19:15]]; rs2_data = regs[w[24:20]];
    #1;
  endtask

  task automatic tick();
    dec_t d;
    bit acc;
    acc = instr_valid && m_ready();
    d = ref_dec(instr, pc, rs1_data, rs2_data);
    @(posedge clk);
    if (rst) begin
      exp_o = IDLE;
      hist = {};
      for (int i = 0; i < D; i++) hist.push_back(0);
    end else if (!stall) begin
      if (acc) begin
        exp_o = d.o;
        hist.push_front(d.o.we ? int'(d.o.rd) : 0);
      end else begin
        exp_o = IDLE;
        hist.push_front(0);
      end
      void'(hist.pop_back());
    end
    #1;
  endtask

  function automatic outv_t dut_o();
    return '{op: op, in1: in1, in2: in2, rd: rd, we: rd_we, valid: out_valid, ill: illegal};
  endfunction

  task automatic flush();
    for (int i = 0; i < D + 1; i++) begin drive(1'b0, 32'h00000013, 32'd0, 1'b0); tick(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin drive(1'b1, 32'h00500093, 32'd0, 1'b1); tick(); end
    n_checks++;
    if (dut_o() !== IDLE) begin
      n_fail++; $display("FAIL reset_outputs got %h want %h", dut_o(), IDLE);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'd0, 1'b0);
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", instr_ready);
    end
    tick();
  endtask

  task automatic test_addi();
    outv_t want;
    want = '{op: A_ADD, in1: 32'd0, in2: 32'd5, rd: 5'd1, we: 1'b1, valid: 1'b1, ill: 1'b0};
    flush();
    drive(1'b1, 32'h00500093, 32'd0, 1'b0);
    n_checks++;
    if (rs1_addr !== 5'd0 || rs2_addr !== 5'd5 || instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL addi_addr got %0d/%0d/%b want 0/5/1", rs1_addr, rs2_addr, instr_ready);
    end
    tick();
    n_checks++;
    if (dut_o() !== want) begin
      n_fail++; $display("FAIL addi_issue got %h want %h", dut_o(), want);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    bit done = 0;
    flush();
    drive(1'b1, 32'h00500093, 32'd0, 1'b0);
    tick();
    regs[1] = 32'd5;  // writeback of x1 becomes visible to the re-read
    for (int i = 0; i < 8 && !done; i++) begin
      drive(1'b1, 32'h00108133, 32'd4, 1'b0);
      if (instr_ready) done = 1; else stalls++;
      tick();
      n_checks++;
      if (dut_o() !== exp_o) begin
        n_fail++; $display("FAIL b2b_cycle%0d got %h want %h", i, dut_o(), exp_o);
      end
    end
    n_checks++;
    if (!done || stalls != 2) begin
      n_fail++; $display("FAIL b2b_bubbles got %0d (accepted=%b) want 2", stalls, done);
    end
    n_checks++;
    if (op !== A_ADD || in1 !== 32'd5 || in2 !== 32'd5 || rd !== 5'd2 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_add got op=%0d in1=%h in2=%h rd=%0d want op=0 in1=5 in2=5 rd=2", op, in1, in2, rd);
    end
  endtask

  task automatic test_imm_forms();
    logic [31:0] words [3];
    logic [31:0] want2 [3];
    logic [3:0]  wantop [3];
    words = '{32'hFFF0A093, 32'h4030D093, 32'h005211B3};
    want2 = '{32'hFFFFFFFF, 32'h00000003, 32'h00000003};
    wantop = '{A_SLT, A_SRA, A_SLL};
    regs[5] = 32'h00000123;
    for (int k = 0; k < 3; k++) begin
      flush();
      drive(1'b1, words[k], 32'd0, 1'b0);
      tick();
      n_checks++;
      if (op !== wantop[k] || in2 !== want2[k] || in1 !== regs[words[k][19:15]] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL imm_form%0d got op=%0d in1=%h in2=%h want op=%0d in2=%h", k, op, in1, in2, wantop[k], want2[k]);
      end
    end
  endtask

  task automatic test_auipc_illegal();
    outv_t w1, w2;
    w1 = '{op: A_ADD, in1: 32'h100, in2: 32'h12345000, rd: 5'd0, we: 1'b0, valid: 1'b1, ill: 1'b0};
    w2 = '{op: A_ADD, in1: 32'd0, in2: 32'd0, rd: 5'd0, we: 1'b0, valid: 1'b1, ill: 1'b1};
    flush();
    drive(1'b1, 32'h12345017, 32'h100, 1'b0); tick();
    n_checks++;
    if (dut_o() !== w1) begin
      n_fail++; $display("FAIL auipc got %h want %h", dut_o(), w1);
    end
    drive(1'b1, 32'h02000033, 32'h104, 1'b0); tick();
    n_checks++;
    if (dut_o() !== w2) begin
      n_fail++; $display("FAIL illegal_funct7 got %h want %h", dut_o(), w2);
    end
  endtask

  task automatic test_stall();
    outv_t held;
    int stalls = 0;
    bit done = 0;
    flush();
    regs[1] = 32'h0000_0077;
    drive(1'b1, 32'h00500093, 32'd0, 1'b0); tick();
    held = exp_o;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00108133, 32'd4, 1'b1);
      n_checks++;
      if (instr_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready%0d got %b want 0", i, instr_ready);
      end
      tick();
      n_checks++;
      if (dut_o() !== held) begin
        n_fail++; $display("FAIL stall_hold%0d got %h want %h", i, dut_o(), held);
      end
    end
    for (int i = 0; i < 8 && !done; i++) begin
      drive(1'b1, 32'h00108133, 32'd4, 1'b0);
      if (instr_ready) done = 1; else stalls++;
      tick();
    end
    n_checks++;
    if (!done || stalls != 2 || dut_o() !== exp_o) begin
      n_fail++; $display("FAIL stall_resume got bubbles=%0d out=%h want bubbles=2 out=%h", stalls, dut_o(), exp_o);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [4:0] r1, r2, rdn;
    logic [2:0] f3;
    int k;
    r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3)); rdn = 5'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7));
    k = $urandom_range(0, 9);
    w = $urandom;
    case (k)
      0, 1, 2: w = {($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, r2, r1, f3, rdn, 7'h33};
      3, 4, 5: w = {w[31:20], r1, f3, rdn, 7'h13};
      6: w = {($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00, w[24:20], r1, f3, rdn, 7'h13};
      7: w = {w[31:12], rdn, 7'h37};
      8: w = {w[31:12], rdn, 7'h17};
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int r = 1; r < 32; r++) if ($urandom_range(0, 7) == 0) regs[r] = $urandom;
      drive(($urandom_range(0, 4) != 0), rand_word(), $urandom, ($urandom_range(0, 4) == 0));
      n_checks++;
      if (instr_ready !== m_ready() || rs1_addr !== instr[19:15] || rs2_addr !== instr[24:20]) begin
        n_fail++; $display("FAIL rand_ready%0d got %b want %b", i, instr_ready, m_ready());
      end
      tick();
      n_checks++;
      if (dut_o() !== exp_o) begin
        n_fail++; $display("FAIL rand_out%0d got %h want %h", i, dut_o(), exp_o);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'd0 : $urandom;
    exp_o = IDLE;
    for (int i = 0; i < D; i++) hist.push_back(0);
    test_reset();
    test_addi();
    test_back_to_back();
    test_imm_forms();
    test_auipc_illegal();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decode.md
Name: alu_decode

Overview:
- Decode/issue stage directly upstream of the registered RV32I ALU.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Drives register-file read addresses and produces registered ALU op, operands and destination info for the ALU and writeback.
- Inserts bubbles on read-after-write hazards against in-flight writers.

Parameters:
HAZARD_DEPTH, 2, number of most recently issued writers checked for RAW hazards (legal range 1..3).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instr/pc valid
instr_ready  output  1  stage accepts instr this cycle (combinational)
instr  input  32  RV32I instruction word
pc  input  32  address of instr
rs1_addr  output  5  regfile read address, combinational = instr[19:15]
rs2_addr  output  5  regfile read address, combinational = instr[24:20]
rs1_data  input  32  regfile read data for rs1_addr, same cycle
rs2_data  input  32  regfile read data for rs2_addr, same cycle
stall  input  1  downstream hold; freezes all outputs and tracker
op  output  4  ALU opcode, ALU_* encodings from rv32i.vh
in1  output  32  ALU operand 1
in2  output  32  ALU operand 2
rd  output  5  destination register
rd_we  output  1  writeback enable
out_valid  output  1  outputs carry an issued instruction
illegal  output  1  issued word was not a supported ALU instruction

Behaviour:
- Reset, which dominates stall: op=ALU_ADD, in1=in2=0, rd=0, rd_we=0, out_valid=0, illegal=0; hazard tracker cleared.
- instr_ready = !stall && !hazard. Accept = instr_valid && instr_ready. Latency is 1 cycle: decoded fields are registered at the accept edge.
- stall=1: every output register and tracker entry holds its value.
- stall=0 and no accept: insert a bubble. out_valid=0, rd_we=0, illegal=0, op=ALU_ADD, in1=in2=rd=0.
- Decode, per opcode:
  - OP (0110011): in1=rs1_data.
    - in2=rs2_data for ADD/SUB/SLT/SLTU/XOR/OR/AND.
    - For SLL/SRL/SRA, in2={27'b0, rs2_data[4:0]}.
    - funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Any other funct7 is illegal.
  - OP-IMM (0010011): in1=rs1_data, in2=sign-extended imm[11:0].
    - SLTIU compares against the sign-extended imm.
    - SLLI/SRLI/SRAI: in2={27'b0, instr[24:20]}.
    - SLLI requires funct7=0. SRLI/SRAI require funct7 0000000/0100000.
  - LUI: op=ADD, in1=0, in2={instr[31:12], 12'b0}.
  - AUIPC: op=ADD, in1=pc, in2={instr[31:12], 12'b0}.
  - Any other opcode or illegal funct: out_valid=1, illegal=1, rd_we=0, op=ALU_ADD, in1=in2=0.
- rd_we=1 for legal instructions with rd!=0. rd=instr[11:7] always.
- Source use: rs1 is used by OP and OP-IMM; rs2 by OP only. LUI/AUIPC/illegal use neither.
- Hazard tracker: HAZARD_DEPTH-entry shift register of {rd, rd_we}.
  - Shifts on every non-stall cycle, inserting the issued entry, or {0,0} for a bubble.
  - hazard=1 when a used source register !=0 matches any entry with rd_we=1.
- Resulting spacing with default depth: dependent instruction at distance 1 gets 2 bubbles, distance 2 gets 1, distance 3+ gets none.
- instr_valid=0 never raises hazard. Accepted words are never dropped or duplicated.
- rs1_addr/rs2_addr are driven from instr regardless of instr_valid.

Test Plan:
- Reset: rst=1 with stall=1 for 2 cycles -> out_valid=0, op=ALU_ADD, in1=in2=0, rd_we=0; instr_ready=1 after release with stall=0.
- 0x00500093 (ADDI x1,x0,5), rs1_data=0 -> next cycle op=ALU_ADD, in1=0, in2=5, rd=1, rd_we=1, out_valid=1.
- 0x00500093 then 0x00108133 (ADD x2,x1,x1) back-to-back -> instr_ready low 2 cycles, 2 bubbles (out_valid=0), then ADD issues with rs1/rs2 re-read.
- 0xFFF0A093 (SLTI x1,x1,-1) -> in2=0xFFFFFFFF. 0x4030D093 (SRAI x1,x1,3) -> op=ALU_SRA, in2=3. R-type SLL with rs2_data=0x00000123 -> in2=0x03.
- 0x12345017 (AUIPC x0) at pc=0x100 -> in1=0x100, in2=0x12345000, rd_we=0. 0x02000033 (funct7=0000001) -> illegal=1, out_valid=1, rd_we=0.
- Stall asserted for 3 cycles after an issue -> all outputs frozen, instr_ready=0. Hazard countdown resumes only after stall drops.
